// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: opcodes, field positions, FSM states.
// Pure package: no ports, no logic latency, no backpressure.
// Instruction word layout: op[15:12] rs[11:9] rt[8:6] rd[5:3] func[2:0] / imm[5:0].
package instr_encoder_pkg;

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_ANDI = 4'b0010;
  localparam logic [3:0] OP_ORI  = 4'b0011;
  localparam logic [3:0] OP_NORI = 4'b0100;
  localparam logic [3:0] OP_BEQ  = 4'b0101;
  localparam logic [3:0] OP_BNE  = 4'b0110;
  localparam logic [3:0] OP_SLTI = 4'b0111;
  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1001;

  localparam int OP_HI   = 15;
  localparam int OP_LO   = 12;
  localparam int RS_HI   = 11;
  localparam int RS_LO   = 9;
  localparam int RT_HI   = 8;
  localparam int RT_LO   = 6;
  localparam int RD_HI   = 5;
  localparam int RD_LO   = 3;
  localparam int FUNC_HI = 2;
  localparam int FUNC_LO = 0;
  localparam int IMM_HI  = 5;
  localparam int IMM_LO  = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Opcodes above sw (1010..1111) are unassigned.
  function automatic logic is_legal(input logic [3:0] op);
    return (op <= OP_SW);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Packs one field record into a 16-bit instruction word (R-format for op 0, I-format otherwise).
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
// Ports: op/rs/rt/rd/func/imm field inputs -> word (16-bit encoded instruction).
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [2:0]  rs,
  input  logic [2:0]  rt,
  input  logic [2:0]  rd,
  input  logic [2:0]  func,
  input  logic [5:0]  imm,
  output logic [15:0] word
);

  always_comb begin
    word = '0;
    word[OP_HI:OP_LO] = op;
    word[RS_HI:RS_LO] = rs;
    word[RT_HI:RT_LO] = rt;
    if (op == OP_R) begin
      word[RD_HI:RD_LO]     = rd;
      word[FUNC_HI:FUNC_LO] = func;
    end else begin
      // Every non-R opcode (including unassigned ones) uses the immediate layout.
      word[IMM_HI:IMM_LO] = imm;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Loads a session of field records into instruction memory, one encoded word per record.
// Latency: write happens the cycle after acceptance; peak one word per 2 cycles.
// Backpressure: in_ready high only in ACCEPT; held low while writing or finishing.
// Ports: clk, rst_n (async active-low), start/base_addr arm a session; in_valid/in_ready
// handshake with in_op/in_rs/in_rt/in_rd/in_func/in_imm/in_last; imem_we/imem_addr/imem_wdata
// write port; busy, done (pulse), count (words written), err_illegal (sticky).
// Build option INSTR_ENCODER_LEGAL_CHECK_EN: drop and flag opcodes 1010..1111 instead of writing them.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [2:0]        in_rs,
  input  logic [2:0]        in_rt,
  input  logic [2:0]        in_rd,
  input  logic [2:0]        in_func,
  input  logic [5:0]        in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err_illegal
);

  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   cnt_inc;
  logic [15:0]       word_q;
  logic [15:0]       packed_word;
  logic              last_q;
  logic              accept;
  logic              illegal;

  instr_pack u_pack (
    .op   (in_op),
    .rs   (in_rs),
    .rt   (in_rt),
    .rd   (in_rd),
    .func (in_func),
    .imm  (in_imm),
    .word (packed_word)
  );

  assign accept  = in_valid && (state == ACCEPT);
  assign cnt_inc = cnt + CNT_ONE;

`ifdef INSTR_ENCODER_LEGAL_CHECK_EN
  logic err_q;
  assign illegal = !is_legal(in_op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if ((state == IDLE) && start) begin
      err_q <= 1'b0;
    end else if (accept && illegal) begin
      err_q <= 1'b1;
    end
  end

  assign err_illegal = err_q;
`else
  assign illegal     = 1'b0;
  assign err_illegal = 1'b0;
`endif

  // Outputs decode straight from state so reset forces them low asynchronously.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    imem_we   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ACCEPT;
      end
      ACCEPT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (illegal) state_nxt = in_last ? DONE : ACCEPT;
          else         state_nxt = WRITE;
        end
      end
      WRITE: begin
        imem_we = 1'b1;
        // cnt_inc MSB set means the whole address space has been filled.
        if (last_q || cnt_inc[ADDR_W]) state_nxt = DONE;
        else                            state_nxt = ACCEPT;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= '0;
      cnt    <= '0;
      word_q <= '0;
      last_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && start) begin
        ptr <= base_addr;
        cnt <= '0;
      end
      if (accept && !illegal) begin
        word_q <= packed_word;
        last_q <= in_last;
      end
      if (state == WRITE) begin
        ptr <= ptr + PTR_ONE;  // wraps silently at all-ones
        cnt <= cnt_inc;
      end
    end
  end

  assign imem_addr  = ptr;
  assign imem_wdata = word_q;
  assign count      = cnt;

endmodule
